tdm_demux16: RTL and testbench

Receive-side time-division demultiplexer for the 16-channel serial link driven by the team's 16:1 mux with a free-running select counter. It accepts one serial bit per valid beat and steers slot k to output channel k. It aligns on an explicit frame marker and presents each complete 16-bit frame as a registered parallel word with a one-cycle strobe. It sits between the serial link and the parallel consumer logic.

---
 rtl/tdm_demux16.sv | 89 ++++++++
 tb/tb_tdm_demux16.sv | 120 ++++++++++++
 2 files changed

// File: rtl/tdm_demux16.sv
// Receive-side 16-slot TDM demultiplexer: aligns on frame_start, collects one
// bit per accepted beat and emits each complete frame as a registered word.
module tdm_demux16 #(
   parameter int unsigned N  = 16,
   parameter int unsigned SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   input  logic          din_valid,
   input  logic          frame_start,
   output logic [N-1:0]  y,
   output logic          frame_valid,
   output logic [SW-1:0] slot,
   output logic          locked,
   output logic          sync_err
);

   typedef enum logic {HUNT, RECV} state_t;

   state_t        state, state_n;
   logic [SW-1:0] slot_n;
   logic [N-1:0]  frame_buf, frame_buf_n;
   logic [N-1:0]  y_n;
   logic          frame_valid_n;
   logic          sync_err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         slot        <= '0;
         frame_buf   <= '0;
         y           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         frame_buf   <= frame_buf_n;
         y           <= y_n;
         frame_valid <= frame_valid_n;
         sync_err    <= sync_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      slot_n        = slot;
      frame_buf_n   = frame_buf;
      y_n           = y;
      frame_valid_n = 1'b0;
      sync_err_n    = 1'b0;
      if (din_valid) begin
         unique case (state)
            HUNT: begin
               if (frame_start) begin
                  frame_buf_n[0] = din;
                  slot_n         = SW'(1);
                  state_n        = RECV;
               end
            end
            RECV: begin
               if (frame_start) begin
                  // an early marker restarts the frame; stale buffer bits get overwritten before any emit
                  sync_err_n     = (slot != '0);
                  frame_buf_n[0] = din;
                  slot_n         = SW'(1);
               end else if (slot == '0) begin
                  sync_err_n = 1'b1;
                  state_n    = HUNT;
               end else begin
                  frame_buf_n[slot] = din;
                  if (slot == SW'(N - 1)) begin
                     y_n           = {din, frame_buf[N-2:0]};
                     frame_valid_n = 1'b1;
                     slot_n        = '0;
                  end else begin
                     slot_n = slot + SW'(1);
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux16.sv
// Table-driven bench for tdm_demux16: each record holds one cycle of inputs
// and the outputs expected just after that rising edge.
module tb_tdm_demux16;

   logic        clk = 1'b0;
   logic        rst, din, din_valid, frame_start;
   logic [15:0] y;
   logic        frame_valid, locked, sync_err;
   logic [3:0]  slot;

   tdm_demux16 #(.N(16), .SW(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_start(frame_start), .y(y), .frame_valid(frame_valid),
      .slot(slot), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          phase;
      logic        rst, dv, fs, d;
      logic [15:0] ey;
      logic        efv, elk;
      logic [3:0]  eslot;
      logic        ese;
      logic        cslot;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   ph     = 0;

   task automatic add(input logic r, input logic dv, input logic fs, input logic d,
                      input logic [15:0] ey, input logic efv, input logic elk,
                      input logic [3:0] eslot, input logic ese, input logic cslot);
      vec_t v;
      v.phase = ph; v.rst = r; v.dv = dv; v.fs = fs; v.d = d;
      v.ey = ey; v.efv = efv; v.elk = elk; v.eslot = eslot; v.ese = ese; v.cslot = cslot;
      vecs.push_back(v);
   endtask

   // Beats for slots first..last of word w (marker on slot 0), locked throughout.
   task automatic beats(input logic [15:0] w, input logic [15:0] yprev,
                        input int unsigned first, input int unsigned last, input bit stall);
      for (int unsigned k = first; k <= last; k++) begin
         add(1'b0, 1'b1, k == 0, w[k], (k == 15) ? w : yprev, k == 15, 1'b1,
             4'((k + 1) % 16), 1'b0, 1'b1);
         if (stall && (k == 4 || k == 11))
            for (int unsigned s = 0; s < 3; s++)
               add(1'b0, 1'b0, 1'b0, 1'b1, yprev, 1'b0, 1'b1, 4'(k + 1), 1'b0, 1'b1);
      end
   endtask

   function automatic void chk(input int idx, input string nm, input logic [15:0] got,
                               input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL vec %0d phase %0d %s: got %h want %h", idx, vecs[idx].phase, nm, got, want);
      end
   endfunction

   initial begin
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;

      ph = 0; // reset, then an idle cycle
      add(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

      ph = 1; // basic frame
      beats(16'h5441, 16'h0000, 0, 15, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'h5441, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

      ph = 2; // back-to-back
      beats(16'h5441, 16'h5441, 0, 15, 1'b0);
      beats(16'hFFFF, 16'h5441, 0, 15, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

      ph = 3; // stalls after slots 4 and 11
      beats(16'h5441, 16'hFFFF, 0, 15, 1'b1);

      ph = 4; // early marker at slot 9
      beats(16'hFFFF, 16'h5441, 0, 8, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 16'h5441, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
      beats(16'h00A5, 16'h5441, 1, 15, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

      ph = 5; // missing marker
      beats(16'h1234, 16'h00A5, 0, 15, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 5; i++)
         add(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      beats(16'h00FF, 16'h1234, 0, 15, 1'b0);

      ph = 6; // reset at slot 7, leftover beats ignored, then a fresh frame
      beats(16'hBEEF, 16'h00FF, 0, 6, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      for (int unsigned k = 8; k < 16; k++)
         add(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      beats(16'hA5A5, 16'h0000, 0, 15, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; din_valid = vecs[i].dv;
         frame_start = vecs[i].fs; din = vecs[i].d;
         @(posedge clk); #1;
         chk(i, "y", y, vecs[i].ey);
         chk(i, "frame_valid", 16'(frame_valid), 16'(vecs[i].efv));
         chk(i, "locked", 16'(locked), 16'(vecs[i].elk));
         chk(i, "sync_err", 16'(sync_err), 16'(vecs[i].ese));
         if (vecs[i].cslot) chk(i, "slot", 16'(slot), 16'(vecs[i].eslot));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
